// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling.
// rx is synchronized through two flops, then sampled in the middle of each
// bit by counting s_tick strobes. dout, frame_err (and parity_err) are
// registered and change only together with rx_done_tick.
// Optional build macro: UART_RX_PARITY_EN adds an even-parity bit after the
// data bits and the parity_err output.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | counting to the middle of the start bit, rejecting glitches
// DATA   | sampling DBIT data bits, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | waiting out the stop bit, then completing the frame
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic            parity_err
`endif
);

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd3;
`endif
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]      state;
    logic [3:0]      s;
    logic [NW-1:0]   n;
    logic [DBIT-1:0] b;
    logic            rx_meta;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    // Two-flop synchronizer; resets to idle-high so release cannot look like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with tick counter, bit counter, shift register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= 4'd0;
            n            <= '0;
            b            <= '0;
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // Level detect, not gated by s_tick, so the start-bit
                    // midpoint count begins as early as possible.
                    if (!rx_s) begin
                        state <= START;
                        s     <= 4'd0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == 4'd7) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= 4'd0;
                                n     <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == 4'd15) begin
                            b <= {rx_s, b[DBIT-1:1]};
                            s <= 4'd0;
                            if (n == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n <= n + 1'b1;
                            end
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s == 4'd15) begin
                            par_bit <= rx_s;
                            s       <= 4'd0;
                            state   <= STOP;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        if (s == 4'(SB_TICK - 1)) begin
                            // A low stop sample still completes the frame, flagged as a framing error.
                            rx_done_tick <= 1'b1;
                            dout         <= b;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= (^b) ^ par_bit;
`endif
                            state        <= IDLE;
                        end else begin
                            s <= s + 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx (DBIT=8, SB_TICK=16).
// s_tick is generated every TICK_DIV clocks; serial bits last 16 ticks each.
module tb_uart_rx;

    localparam int TICK_DIV = 8;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_TICKS = 8 + 16 * 8 + 16 + 16;
`else
    localparam int FRAME_TICKS = 8 + 16 * 8 + 16;
`endif

    logic       clk;
    logic       reset;
    logic       rx;
    logic       s_tick;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int checks = 0;
    int errors = 0;
    int div_cnt = 0;
    int tick_cnt = 0;
    int done_cnt = 0;
    int done_tick_at = 0;
    logic [7:0] last_dout;
    logic       last_ferr;
    logic [7:0] prev_dout = 8'h00;
    logic [7:0] hist[$];

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tick generator, changes on the falling edge.
    initial s_tick = 1'b0;
    always @(negedge clk) begin
        if (div_cnt == TICK_DIV - 1) begin
            div_cnt = 0;
            s_tick  = 1'b1;
        end else begin
            div_cnt = div_cnt + 1;
            s_tick  = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (s_tick) tick_cnt = tick_cnt + 1;
    end

    // Completion monitor; also checks that dout only moves with rx_done_tick.
    always @(negedge clk) begin
        if (rx_done_tick) begin
            done_cnt     = done_cnt + 1;
            last_dout    = dout;
            last_ferr    = frame_err;
            done_tick_at = tick_cnt;
            hist.push_back(dout);
        end
        if (!reset && dout !== prev_dout) begin
            checks = checks + 1;
            if (rx_done_tick !== 1'b1) begin
                errors = errors + 1;
                $display("FAIL dout_change_without_done: dout %h -> %h, rx_done_tick=%b required 1",
                         prev_dout, dout, rx_done_tick);
            end
        end
        prev_dout = dout;
    end

    task automatic wait_ticks(input int cnt);
        repeat (cnt) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_head(input logic [7:0] data, input logic par);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_ticks(16);
`else
        if (par === 1'bx) rx = 1'b1;
`endif
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par);
        send_head(data, par);
        rx = 1'b1;
        wait_ticks(16);
    endtask

    task automatic wait_done(input int prev, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt > prev) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
        checks++;
        if (rx_done_tick !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", rx_done_tick); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
`ifdef UART_RX_PARITY_EN
        checks++;
        if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
`endif
        reset = 1'b0;
        wait_ticks(20);
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL reset_no_false_start: got %0d done pulses expected 0", done_cnt); end
    endtask

    task automatic test_basic;
        int prev;
        int start_tick;
        bit ok;
        prev       = done_cnt;
        start_tick = tick_cnt;
        send_frame(8'h55, 1'b0);
        wait_done(prev, ok);
        wait_ticks(4);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got no rx_done_tick expected one"); end
        checks++;
        if (done_cnt - prev !== 1) begin errors++; $display("FAIL basic_pulse_count: got %0d expected 1", done_cnt - prev); end
        checks++;
        if (last_dout !== 8'h55) begin errors++; $display("FAIL basic_dout: got %h expected 55", last_dout); end
        checks++;
        if (last_ferr !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", last_ferr); end
        checks++;
        if (done_tick_at - start_tick !== FRAME_TICKS) begin
            errors++;
            $display("FAIL basic_latency: got %0d ticks expected %0d", done_tick_at - start_tick, FRAME_TICKS);
        end
    endtask

    task automatic test_frame_err;
        int prev;
        bit ok;
        prev = done_cnt;
        send_head(8'hA3, 1'b0);
        rx = 1'b0;
        wait_ticks(10);
        rx = 1'b1;
        wait_ticks(6);
        wait_done(prev, ok);
        wait_ticks(40);
        checks++;
        if (!ok || done_cnt - prev !== 1) begin errors++; $display("FAIL ferr_pulse_count: got %0d expected 1", done_cnt - prev); end
        checks++;
        if (last_dout !== 8'hA3) begin errors++; $display("FAIL ferr_dout: got %h expected a3", last_dout); end
        checks++;
        if (last_ferr !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", last_ferr); end
        checks++;
        if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_held: got %b expected 1", frame_err); end
        prev = done_cnt;
        send_frame(8'h0F, 1'b0);
        wait_done(prev, ok);
        wait_ticks(4);
        checks++;
        if (!ok || last_dout !== 8'h0F) begin errors++; $display("FAIL ferr_next_dout: got %h expected 0f", last_dout); end
        checks++;
        if (last_ferr !== 1'b0) begin errors++; $display("FAIL ferr_next_flag: got %b expected 0", last_ferr); end
    endtask

    task automatic test_glitch;
        int prev;
        prev = done_cnt;
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(30);
        checks++;
        if (done_cnt !== prev) begin errors++; $display("FAIL glitch_no_done: got %0d pulses expected 0", done_cnt - prev); end
        checks++;
        if (dout !== 8'h0F) begin errors++; $display("FAIL glitch_dout: got %h expected 0f", dout); end
        checks++;
        if (dut.state !== 3'd0) begin errors++; $display("FAIL glitch_idle: got state %0d expected 0", dut.state); end
    endtask

    task automatic test_back_to_back;
        int prev;
        int h0;
        prev = done_cnt;
        h0   = hist.size();
        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        wait_ticks(20);
        checks++;
        if (done_cnt - prev !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", done_cnt - prev); end
        checks++;
        if (hist.size() < h0 + 2 || hist[h0] !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first: got %h expected 00", (hist.size() > h0) ? hist[h0] : 8'hxx);
        end
        checks++;
        if (hist.size() < h0 + 2 || hist[h0+1] !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second: got %h expected ff", (hist.size() > h0 + 1) ? hist[h0+1] : 8'hxx);
        end
    endtask

    task automatic test_reset_midframe;
        int prev;
        bit ok;
        prev = done_cnt;
        rx = 1'b0;
        wait_ticks(16);
        rx = 1'b1;
        wait_ticks(48 + 8);
        reset = 1'b1;
        #1;
        checks++;
        if (dout !== 8'h00) begin errors++; $display("FAIL rst_mid_dout: got %h expected 00", dout); end
        checks++;
        if (rx_done_tick !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_flags: got done=%b ferr=%b expected 0 0", rx_done_tick, frame_err);
        end
        checks++;
        if (dut.state !== 3'd0) begin errors++; $display("FAIL rst_mid_state: got %0d expected 0", dut.state); end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(20);
        checks++;
        if (done_cnt !== prev) begin errors++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - prev); end
        send_frame(8'h81, 1'b0);
        wait_done(prev, ok);
        wait_ticks(4);
        checks++;
        if (!ok || last_dout !== 8'h81) begin errors++; $display("FAIL rst_mid_after: got %h expected 81", last_dout); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int prev;
        bit ok;
        prev = done_cnt;
        send_frame(8'h07, 1'b1);
        wait_done(prev, ok);
        wait_ticks(4);
        checks++;
        if (!ok || parity_err !== 1'b0) begin errors++; $display("FAIL parity_good: got %b expected 0", parity_err); end
        prev = done_cnt;
        send_frame(8'h07, 1'b0);
        wait_done(prev, ok);
        wait_ticks(4);
        checks++;
        if (!ok || parity_err !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b expected 1", parity_err); end
        checks++;
        if (last_dout !== 8'h07) begin errors++; $display("FAIL parity_dout: got %h expected 07", last_dout); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        test_reset();
        test_basic();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
